// File: rtl/opn_bus_master.sv
`timescale 1ns/1ps
// YM2608 CPU-bus initiator: queues (port, reg, value) writes and plays them out as address/data strobes.
// Optional chip busy-flag polling before each write is enabled with OPN_BUSY_POLL_EN.
module opn_bus_master #(
    parameter int FIFO_AW      = 4,
    parameter int STROBE_LEN   = 2,
    parameter int ADDR_GAP     = 2,
    parameter int DATA_WAIT    = 32,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_port,
    input  logic [7:0]       req_reg,
    input  logic [7:0]       req_data,
    output logic [FIFO_AW:0] fifo_level,
    output logic             busy,
    output logic             timeout_err,
    input  logic             clr_err,
    output logic [7:0]       opn_din,
    output logic [1:0]       opn_addr,
    output logic             opn_cs_n,
    output logic             opn_wr_n,
    input  logic [7:0]       opn_dout
);
    localparam int DEPTH = 1 << FIFO_AW;
`ifdef OPN_BUSY_POLL_EN
    localparam bit POLL_EN = 1'b1;
    localparam logic [9:0] TIMEOUT_LAST = 10'(BUSY_TIMEOUT - 1);
`else
    localparam bit POLL_EN = 1'b0;
`endif
    localparam int DGAP_TICKS = POLL_EN ? 1 : ((DATA_WAIT > 0) ? DATA_WAIT : 1);
    localparam logic [9:0] STROBE_LAST = 10'(STROBE_LEN - 1);
    localparam logic [9:0] GAP_LAST    = 10'((ADDR_GAP > 0) ? ADDR_GAP - 1 : 0);
    localparam logic [9:0] DGAP_LAST   = 10'(DGAP_TICKS - 1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   LVL_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, POLL, AWR, AGAP, DWR, DGAP} state_t;

    state_t             state;
    logic [16:0]        mem [DEPTH];
    logic [16:0]        head;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               cur_port;
    logic [7:0]         cur_reg;
    logic [7:0]         cur_data;
    logic [9:0]         cnt;
    logic               unused_inputs;

    assign full      = (fifo_level == LVL_FULL);
    assign empty     = (fifo_level == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = cen && (state == IDLE) && !empty;
    assign busy      = !empty || (state != IDLE);
    assign head      = mem[rd_ptr];

    // FIFO storage and the latched current entry carry no reset; only pointers/level do.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {req_port, req_reg, req_data};
        if (pop)
            {cur_port, cur_reg, cur_data} <= head;
    end

    // Pushes are not gated by cen; pops only happen on an IDLE tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            opn_cs_n <= 1'b1;
            opn_wr_n <= 1'b1;
            opn_addr <= 2'b00;
            opn_din  <= 8'h00;
`ifdef OPN_BUSY_POLL_EN
            timeout_err <= 1'b0;
`endif
        end else begin
`ifdef OPN_BUSY_POLL_EN
            // A timeout set later in this block overrides a concurrent clear.
            if (clr_err)
                timeout_err <= 1'b0;
`endif
            if (cen) begin
                case (state)
                    IDLE: begin
                        opn_addr <= 2'b00;
                        cnt      <= '0;
                        if (!empty) begin
`ifdef OPN_BUSY_POLL_EN
                            state    <= POLL;
                            opn_cs_n <= 1'b0;
                            opn_wr_n <= 1'b1;
`else
                            state    <= AWR;
                            opn_cs_n <= 1'b0;
                            opn_wr_n <= 1'b0;
                            opn_addr <= {head[16], 1'b0};
                            opn_din  <= head[15:8];
`endif
                        end
                    end
`ifdef OPN_BUSY_POLL_EN
                    // The first poll tick only opens the read; the flag is trusted from the second on.
                    POLL: begin
                        if ((cnt != '0 && !opn_dout[7]) || cnt == TIMEOUT_LAST) begin
                            if (opn_dout[7])
                                timeout_err <= 1'b1;
                            state    <= AWR;
                            cnt      <= '0;
                            opn_wr_n <= 1'b0;
                            opn_addr <= {cur_port, 1'b0};
                            opn_din  <= cur_reg;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
`endif
                    AWR: begin
                        if (cnt == STROBE_LAST) begin
                            cnt <= '0;
                            if (ADDR_GAP == 0) begin
                                state    <= DWR;
                                opn_addr <= {cur_port, 1'b1};
                                opn_din  <= cur_data;
                            end else begin
                                state    <= AGAP;
                                opn_cs_n <= 1'b1;
                                opn_wr_n <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                    AGAP: begin
                        if (cnt == GAP_LAST) begin
                            state    <= DWR;
                            cnt      <= '0;
                            opn_cs_n <= 1'b0;
                            opn_wr_n <= 1'b0;
                            opn_addr <= {cur_port, 1'b1};
                            opn_din  <= cur_data;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                    DWR: begin
                        if (cnt == STROBE_LAST) begin
                            state    <= DGAP;
                            cnt      <= '0;
                            opn_cs_n <= 1'b1;
                            opn_wr_n <= 1'b1;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                    DGAP: begin
                        if (cnt == DGAP_LAST) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            opn_addr <= 2'b00;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        cnt      <= '0;
                        opn_cs_n <= 1'b1;
                        opn_wr_n <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef OPN_BUSY_POLL_EN
    assign unused_inputs = ^opn_dout[6:0];
`else
    assign timeout_err   = 1'b0;
    assign unused_inputs = ^{clr_err, opn_dout, 10'(BUSY_TIMEOUT)};
`endif

endmodule

// File: tb/tb_opn_bus_master.sv
`timescale 1ns/1ps
// Directed, table-driven bench for opn_bus_master; adapts its expectations to OPN_BUSY_POLL_EN.
module tb_opn_bus_master;
    localparam int STROBE_LEN = 2;
    localparam int ADDR_GAP   = 2;
    localparam int DATA_WAIT  = 32;
`ifdef OPN_BUSY_POLL_EN
    localparam bit POLL_EN = 1'b1;
`else
    localparam bit POLL_EN = 1'b0;
`endif
    localparam int POLL_TICKS = POLL_EN ? 2 : 0;
    localparam int DGAP_TICKS = POLL_EN ? 1 : DATA_WAIT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic       req_valid;
    logic       req_ready;
    logic       req_port;
    logic [7:0] req_reg;
    logic [7:0] req_data;
    logic [4:0] fifo_level;
    logic       busy;
    logic       timeout_err;
    logic       clr_err;
    logic [7:0] opn_din;
    logic [1:0] opn_addr;
    logic       opn_cs_n;
    logic       opn_wr_n;
    logic [7:0] opn_dout;

    opn_bus_master #(
        .FIFO_AW(4), .STROBE_LEN(STROBE_LEN), .ADDR_GAP(ADDR_GAP),
        .DATA_WAIT(DATA_WAIT), .BUSY_TIMEOUT(1023)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .req_valid(req_valid), .req_ready(req_ready), .req_port(req_port),
        .req_reg(req_reg), .req_data(req_data), .fifo_level(fifo_level),
        .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err),
        .opn_din(opn_din), .opn_addr(opn_addr), .opn_cs_n(opn_cs_n),
        .opn_wr_n(opn_wr_n), .opn_dout(opn_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records address/data and start cycle of every write strobe.
    logic       prev_wr = 1'b1;
    logic [1:0] cap_addr[$];
    logic [7:0] cap_din[$];
    int         cap_cyc[$];
    always @(negedge clk) begin
        if (!opn_wr_n && prev_wr && !opn_cs_n) begin
            cap_addr.push_back(opn_addr);
            cap_din.push_back(opn_din);
            cap_cyc.push_back(cyc);
        end
        prev_wr <= opn_wr_n;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_caps();
        cap_addr.delete();
        cap_din.delete();
        cap_cyc.delete();
    endtask

    task automatic push(input logic p, input logic [7:0] r, input logic [7:0] d);
        req_port  = p;
        req_reg   = r;
        req_data  = d;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        check({name, "_done"}, busy, 0);
    endtask

    // Cycle-by-cycle expected waveform of one write started from IDLE with an empty FIFO.
    task automatic check_seq(input string tag, input logic p, input logic [7:0] r, input logic [7:0] d);
        int n;
        logic [1:0] strobe;
        logic [1:0] ea;
        logic [7:0] ed;
        bit ca, cd;
        logic eb;
        n = POLL_TICKS + 2 * STROBE_LEN + ADDR_GAP + DGAP_TICKS + 1;
        @(negedge clk);
        check({tag, "_queued_busy"}, busy, 1);
        check({tag, "_queued_level"}, fifo_level, 1);
        check({tag, "_queued_strobes"}, {opn_cs_n, opn_wr_n}, 2'b11);
        for (int i = 1; i <= n; i++) begin
            int k;
            k = i; ca = 1; cd = 1; eb = 1; ea = 2'b00; ed = r;
            if (k <= POLL_TICKS) begin
                strobe = 2'b01; cd = 0;
            end else begin
                k -= POLL_TICKS;
                if (k <= STROBE_LEN) begin
                    strobe = 2'b00; ea = {p, 1'b0}; ed = r;
                end else if (k <= STROBE_LEN + ADDR_GAP) begin
                    strobe = 2'b11; ca = 0; ed = r;
                end else if (k <= 2 * STROBE_LEN + ADDR_GAP) begin
                    strobe = 2'b00; ea = {p, 1'b1}; ed = d;
                end else if (k <= 2 * STROBE_LEN + ADDR_GAP + DGAP_TICKS) begin
                    strobe = 2'b11; ca = 0; ed = d;
                end else begin
                    strobe = 2'b11; ea = 2'b00; ed = d; eb = 0;
                end
            end
            @(negedge clk);
            check($sformatf("%s_c%0d_cs_wr", tag, i), {opn_cs_n, opn_wr_n}, strobe);
            if (ca) check($sformatf("%s_c%0d_addr", tag, i), opn_addr, ea);
            if (cd) check($sformatf("%s_c%0d_din", tag, i), opn_din, ed);
            check($sformatf("%s_c%0d_busy", tag, i), busy, eb);
        end
    endtask

    typedef struct {
        logic       port;
        logic [7:0] rg;
        logic [7:0] dat;
        logic [1:0] a_addr;
        logic [1:0] d_addr;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{1'b0, 8'h28, 8'hF0, 2'd0, 2'd1};
        vecs[1] = '{1'b1, 8'h10, 8'h80, 2'd2, 2'd3};
        vecs[2] = '{1'b0, 8'hA5, 8'h5A, 2'd0, 2'd1};
        vecs[3] = '{1'b1, 8'hFF, 8'h00, 2'd2, 2'd3};

        rst_n = 1'b0; cen = 1'b1; req_valid = 1'b0; req_port = 1'b0;
        req_reg = 8'h00; req_data = 8'h00; clr_err = 1'b0; opn_dout = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_wr", {opn_cs_n, opn_wr_n}, 2'b11);
        check("rst_addr_din", {opn_addr, opn_din}, 10'h000);
        check("rst_level", fifo_level, 0);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            clear_caps();
            push(vecs[v].port, vecs[v].rg, vecs[v].dat);
            check_seq($sformatf("vec%0d", v), vecs[v].port, vecs[v].rg, vecs[v].dat);
            check($sformatf("vec%0d_nstrobes", v), cap_addr.size(), 2);
            if (cap_addr.size() == 2) begin
                check($sformatf("vec%0d_a_strobe", v), {cap_addr[0], cap_din[0]}, {vecs[v].a_addr, vecs[v].rg});
                check($sformatf("vec%0d_d_strobe", v), {cap_addr[1], cap_din[1]}, {vecs[v].d_addr, vecs[v].dat});
            end
        end

`ifndef OPN_BUSY_POLL_EN
        opn_dout = 8'hFF;
        clr_err  = 1'b1;
        push(1'b0, 8'h3C, 8'hC3);
        check_seq("dout_ignored", 1'b0, 8'h3C, 8'hC3);
        check("no_poll_timeout_tied", timeout_err, 0);
        clr_err  = 1'b0;
        opn_dout = 8'h00;
`endif

        // Push lands on the pop tick: level holds, then pacing between entries.
        clear_caps();
        push(1'b0, 8'h21, 8'h12);
        req_port = 1'b1; req_reg = 8'h43; req_data = 8'h34; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("pushpop_level", fifo_level, 1);
        wait_idle("pushpop", 400);
        check("pushpop_nstrobes", cap_addr.size(), 4);
        if (cap_addr.size() == 4) begin
            check("pushpop_order", {cap_addr[0], cap_din[0], cap_addr[1], cap_din[1],
                                    cap_addr[2], cap_din[2], cap_addr[3], cap_din[3]},
                  {2'd0, 8'h21, 2'd1, 8'h12, 2'd2, 8'h43, 2'd3, 8'h34});
            check("entry_spacing", cap_cyc[2] - (cap_cyc[1] + STROBE_LEN - 1),
                  DGAP_TICKS + 1 + POLL_TICKS + 1);
        end

        // Fill with cen low, overflow attempts, then drain in order.
        clear_caps();
        cen = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i == 15) check("fill_ready_at_15", req_ready, 1);
            if (i == 16) begin
                check("full_ready", req_ready, 0);
                check("full_level_before", fifo_level, 16);
            end
            push(i[0], 8'h40 + 8'(i), 8'hC0 ^ 8'(i));
        end
        check("full_level_after_drop", fifo_level, 16);
        check("full_no_strobes", cap_addr.size(), 0);
        req_port = 1'b0; req_reg = 8'h99; req_data = 8'h99; req_valid = 1'b1; cen = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("full_push_pop_level", fifo_level, 15);
        wait_idle("drain", 2000);
        check("drain_nstrobes", cap_addr.size(), 32);
        for (int j = 0; j < 16 && 2 * j + 1 < cap_addr.size(); j++) begin
            check($sformatf("drain%0d_a", j), {cap_addr[2*j], cap_din[2*j]},
                  {j[0], 1'b0, 8'h40 + 8'(j)});
            check($sformatf("drain%0d_d", j), {cap_addr[2*j+1], cap_din[2*j+1]},
                  {j[0], 1'b1, 8'hC0 ^ 8'(j)});
        end

`ifdef OPN_BUSY_POLL_EN
        // Busy flag held, then released: write starts one tick after the first 0 sample.
        clear_caps();
        opn_dout = 8'h80;
        push(1'b0, 8'h30, 8'h11);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("hold_still_polling", {opn_cs_n, opn_wr_n, opn_addr}, 4'b0100);
        opn_dout = 8'h00;
        @(negedge clk);
        check("hold_awr_start", {opn_cs_n, opn_wr_n, opn_addr, opn_din}, {2'b00, 2'd0, 8'h30});
        wait_idle("hold", 200);
        check("hold_no_timeout", timeout_err, 0);

        // Busy flag stuck: timeout on the 1023rd poll tick, write still completes.
        clear_caps();
        opn_dout = 8'h80;
        push(1'b1, 8'h55, 8'hAA);
        repeat (1023) @(posedge clk);
        @(negedge clk);
        check("stuck_pre_timeout", {timeout_err, opn_cs_n, opn_wr_n}, 3'b001);
        @(negedge clk);
        check("stuck_timeout_set", {timeout_err, opn_wr_n}, 2'b10);
        wait_idle("stuck", 200);
        check("stuck_sticky", timeout_err, 1);
        check("stuck_write_done", cap_addr.size(), 2);
        if (cap_addr.size() == 2)
            check("stuck_write_data", {cap_addr[1], cap_din[1]}, {2'd3, 8'hAA});
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err_clears", timeout_err, 0);

        push(1'b0, 8'h66, 8'h77);
        repeat (1023) @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        @(negedge clk);
        check("clr_vs_set", timeout_err, 1);
        wait_idle("stuck2", 200);
        opn_dout = 8'h00;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err_again", timeout_err, 0);
`endif

        // Reset in the middle of a transaction discards the queue and releases strobes.
        push(1'b0, 8'h01, 8'h02);
        push(1'b1, 8'h03, 8'h04);
        push(1'b0, 8'h05, 8'h06);
        @(negedge clk);
        check("midrst_level_before", fifo_level, 2);
        rst_n = 1'b0;
        #1;
        check("midrst_strobes", {opn_cs_n, opn_wr_n, opn_addr}, 4'b1100);
        check("midrst_level", fifo_level, 0);
        check("midrst_busy", busy, 0);
        clear_caps();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("midrst_no_more_writes", cap_addr.size(), 0);
        check("midrst_idle", {busy, opn_cs_n}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/opn_bus_master.md
Name: opn_bus_master

Overview:
- Host-side initiator that drives the YM2608 CPU bus (din/addr/cs_n/wr_n, status on dout).
- Accepts queued register writes of the form (port, register, value), buffers them in a FIFO, and plays each one out as an address-write cycle followed by a data-write cycle.
- Before each write it polls the chip busy flag. Paces itself on the same cen as the sound core.
- Sits between the PC-88 I/O decode and the FM core.

Parameters:
- FIFO_AW, 4: log2 FIFO depth (16 entries).
- STROBE_LEN, 2: cen ticks that cs_n/wr_n are held low per write strobe (min 1).
- ADDR_GAP, 2: idle cen ticks between the address strobe and the data strobe.
- DATA_WAIT, 32: cen ticks of idle after the data strobe. Used only when the poll feature is out.
- BUSY_TIMEOUT, 1023: maximum poll ticks before giving up (10-bit counter).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- cen, in, 1: clock enable. The FSM and all timing counters advance only when cen=1.
- req_valid, in, 1: write request.
- req_ready, out, 1: FIFO not full.
- req_port, in, 1: 0 = ports 0/1 (FM1-3/SSG), 1 = ports 2/3 (FM4-6/ADPCM).
- req_reg, in, 8: register number.
- req_data, in, 8: register value.
- fifo_level, out, FIFO_AW+1: number of queued entries.
- busy, out, 1: FIFO non-empty or FSM not IDLE.
- timeout_err, out, 1: sticky busy-poll timeout flag.
- clr_err, in, 1: clears timeout_err.
- opn_din, out, 8: data bus to the chip.
- opn_addr, out, 2: chip address.
- opn_cs_n, out, 1: chip select.
- opn_wr_n, out, 1: write strobe.
- opn_dout, in, 8: chip read data. Bit 7 is the busy flag.

Behaviour:
- Reset state: FIFO empty; fifo_level=0; req_ready=1; busy=0; timeout_err=0; opn_cs_n=1; opn_wr_n=1; opn_addr=0; opn_din=0; FSM in IDLE.
- Reset asserted mid-transaction: strobes return high immediately and queued entries are discarded.
- All chip-side outputs are registered.
- FIFO:
  - Push on clk when req_valid && req_ready. This happens regardless of cen.
  - req_ready = !full, computed from the registered level. A push at full is dropped even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full leaves fifo_level unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
- FSM states: IDLE, POLL, AWR, AGAP, DWR, DGAP. All transitions occur on cen ticks only.
- IDLE: if the FIFO is non-empty, pop and latch {port, reg, data}, then go to POLL (feature in) or AWR (feature out).
- POLL:
  - Drive cs_n=0, wr_n=1, addr=2'b00.
  - opn_dout[7] is sampled from the 2nd POLL tick onward.
  - Sample 0: go to AWR.
  - Poll counter reaches BUSY_TIMEOUT: set timeout_err and go to AWR anyway.
- AWR: addr={port,0}, din=reg, cs_n=0, wr_n=0 for STROBE_LEN ticks, then go to AGAP.
- AGAP: cs_n=1, wr_n=1 for ADDR_GAP ticks (0 means skip the state), then go to DWR.
- DWR: addr={port,1}, din=data, cs_n=0, wr_n=0 for STROBE_LEN ticks, then go to DGAP.
- DGAP:
  - Feature out: idle DATA_WAIT ticks, then go to IDLE.
  - Feature in: 1 tick, then go to IDLE. The next entry polls before writing.
- opn_din holds its last value when strobes are high. opn_addr returns to 0 in IDLE.
- Back-to-back entries: IDLE consumes exactly 1 tick between transactions.
- timeout_err: if clr_err and a timeout-set occur in the same cycle, set wins.
- busy: goes high the cycle after a push and falls on the tick the FSM enters IDLE with the FIFO empty.

Optional Feature:
- Macro: OPN_BUSY_POLL_EN.
- Defined: POLL state present; pacing follows the chip busy flag; DATA_WAIT is unused.
- Undefined: POLL state removed; opn_dout is ignored; timeout_err is tied to 0; DATA_WAIT sets fixed pacing.

Test Plan:
- cen=1, feature in, opn_dout=0x00, push (0,0x28,0xF0) -> one poll read (cs_n=0, wr_n=1, addr=0 for 2 ticks); then addr=0/din=0x28 low for 2 ticks; 2 idle ticks; then addr=1/din=0xF0 low for 2 ticks; busy falls.
- Push (1,0x10,0x80) -> address strobe on addr=2, data strobe on addr=3.
- opn_dout[7]=1 held for 100 ticks then 0 -> AWR begins the tick after the first sampled 0; timeout_err stays 0.
- opn_dout[7] stuck at 1 -> timeout_err=1 after 1023 poll ticks and the write still completes; clr_err pulse -> 0; clr_err concurrent with a new timeout -> remains 1.
- 17 pushes with cen=0 -> first 16 accepted, req_ready=0, 17th dropped, fifo_level=16; enable cen -> 16 writes complete in FIFO order.
- Feature out, DATA_WAIT=32, two entries -> second address strobe begins exactly 34 ticks after the first data strobe ends (32 DGAP + IDLE + transition).
